link_stripe_aggregator: RTL

- Stripes a single flit stream across NUM_LINKS parallel inter-GPU links, round-robin.
- Tracks a multi-entry credit counter per link.
- Supports a runtime link-enable mask for degraded operation.
- Tags every flit with a global sequence number so the far-end deskew and reorder logic can rebuild order.
- Sits between the fabric egress queue and the per-link PHY adapters.

---
 rtl/link_stripe_aggregator_pkg.sv | 58 +++++
 rtl/link_stripe_aggregator_if.sv | 46 ++++
 rtl/link_stripe_aggregator_credit_ctr.sv | 59 +++++
 rtl/link_stripe_aggregator.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/link_stripe_aggregator_pkg.sv
// ============================================================================
// Package   : link_agg_pkg
// Purpose   : Shared types and helpers for the link stripe aggregator and the
//             receive-side deskew block.
// Contents  : cw_of()         credit-counter width for a given credit depth
//             seq_t/credit_t  sequence tag and credit count types (default cfg)
//             sel_t           link selection result (found flag + index)
//             next_enabled()  first set mask bit at or after a start index
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package link_agg_pkg;

  // Widest link count supported; selection helpers operate on this width.
  localparam int MAX_LINKS  = 16;
  localparam int LINK_IDX_W = 4;

  localparam int SEQ_W_DEF   = 8;
  localparam int CREDITS_DEF = 4;

  // Bits needed to hold the values 0..credits inclusive.
  function automatic int cw_of(input int credits);
    return $clog2(credits + 1);
  endfunction

  typedef logic [SEQ_W_DEF-1:0]            seq_t;
  typedef logic [cw_of(CREDITS_DEF)-1:0]   credit_t;

  typedef struct packed {
    logic                  found;
    logic [LINK_IDX_W-1:0] idx;
  } sel_t;

  // Scans n links starting at 'start' and wrapping modulo n; returns the
  // first index whose mask bit is set. found=0 when no bit in 0..n-1 is set.
  function automatic sel_t next_enabled(input logic [MAX_LINKS-1:0]  mask,
                                        input logic [LINK_IDX_W-1:0] start,
                                        input int                    n);
    sel_t s;
    int   j;
    s = '0;
    j = 0;
    for (int i = 0; i < MAX_LINKS; i++) begin
      if (i < n) begin
        j = (int'(start) + i) % n;
        if (!s.found && mask[j]) begin
          s.found = 1'b1;
          s.idx   = LINK_IDX_W'(j);
        end
      end
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_stripe_aggregator_if.sv
// ============================================================================
// Interface : link_stripe_aggregator_if
// Purpose   : Bundles the flit input handshake, link enable mask, per-link
//             output bus, credit returns and status of the aggregator.
// Modports  : master - egress queue / link side (drives flits, mask, credits)
//             slave  - the aggregator itself
// Signals   : in_flit, in_valid, in_ready, link_en, link_flit, link_seq,
//             link_valid, link_credit, credit_cnt, err_credit_ovf
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

interface link_stripe_aggregator_if #(
  parameter int FLIT_W    = 128,
  parameter int NUM_LINKS = 4,
  parameter int CREDITS   = 4,
  parameter int SEQ_W     = 8
);
  import link_agg_pkg::*;

  localparam int CW = cw_of(CREDITS);

  logic [FLIT_W-1:0]           in_flit;
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_LINKS-1:0]        link_en;
  logic [NUM_LINKS*FLIT_W-1:0] link_flit;
  logic [NUM_LINKS*SEQ_W-1:0]  link_seq;
  logic [NUM_LINKS-1:0]        link_valid;
  logic [NUM_LINKS-1:0]        link_credit;
  logic [NUM_LINKS*CW-1:0]     credit_cnt;
  logic                        err_credit_ovf;

  modport master (
    output in_flit, in_valid, link_en, link_credit,
    input  in_ready, link_flit, link_seq, link_valid, credit_cnt, err_credit_ovf
  );

  modport slave (
    input  in_flit, in_valid, link_en, link_credit,
    output in_ready, link_flit, link_seq, link_valid, credit_cnt, err_credit_ovf
  );

endinterface

`default_nettype wire

// File: rtl/link_stripe_aggregator_credit_ctr.sv
// ============================================================================
// Module    : link_credit_ctr
// Purpose   : Per-link credit counter. Starts full, decrements on send,
//             increments on credit return, saturates at CREDITS and flags a
//             sticky overflow when a return arrives at a full counter.
// Ports     : clk, rst_n      clock, asynchronous active-low reset
//             send            a flit leaves on this link this cycle
//             ret             one credit returned this cycle
//             cnt[CW]         current credit count
//             has_credit      cnt != 0
//             ovf             sticky overflow flag
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module link_credit_ctr #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          send,
  input  logic          ret,
  output logic [CW-1:0] cnt,
  output logic          has_credit,
  output logic          ovf
);

  localparam logic [CW-1:0] C_FULL = CW'(CREDITS);

  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  // send is only ever asserted with has_credit=1, so no underflow path.
  // send together with ret cancels out and leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= C_FULL;
      r_ovf <= 1'b0;
    end else begin
      if (send && !ret) begin
        r_cnt <= r_cnt - CW'(1);
      end else if (ret && !send) begin
        if (r_cnt == C_FULL) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign cnt        = r_cnt;
  assign has_credit = (r_cnt != '0);
  assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: rtl/link_stripe_aggregator.sv
// ============================================================================
// Module    : link_stripe_aggregator
// Purpose   : Stripes one flit stream round-robin across NUM_LINKS links,
//             tagging each flit with a global sequence number and tracking
//             per-link credits. A runtime enable mask removes links from the
//             rotation for degraded operation.
// Ports     : clk            core clock
//             rst_n          asynchronous active-low reset
//             bus (slave)    in_flit/in_valid/in_ready input handshake,
//                            link_en mask, link_flit/link_seq/link_valid
//                            per-link outputs, link_credit returns,
//                            credit_cnt and sticky err_credit_ovf status
// Options   : LINK_SKIP_BUSY_EN - when defined, selection also skips links
//             with no credit (adaptive striping); otherwise the stripe
//             pointer stalls on a credit-starved enabled link.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module link_stripe_aggregator
  import link_agg_pkg::*;
#(
  parameter int FLIT_W    = 128,
  parameter int NUM_LINKS = 4,
  parameter int CREDITS   = 4,
  parameter int SEQ_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  link_stripe_aggregator_if.slave  bus
);

  localparam int CW = cw_of(CREDITS);
  localparam int PW = $clog2(NUM_LINKS);

  logic [PW-1:0]               r_ptr;
  logic [SEQ_W-1:0]            r_seq;
  logic [NUM_LINKS-1:0]        r_link_valid;
  logic [NUM_LINKS*FLIT_W-1:0] r_link_flit;
  logic [NUM_LINKS*SEQ_W-1:0]  r_link_seq;

  logic [NUM_LINKS-1:0]        w_has_credit;
  logic [NUM_LINKS-1:0]        w_ovf;
  logic [NUM_LINKS*CW-1:0]     w_credit_cnt;
  logic [NUM_LINKS-1:0]        w_mask;
  logic [NUM_LINKS-1:0]        w_send;
  sel_t                        w_sel;
  logic                        w_ready;
  logic                        w_accept;
  logic [PW-1:0]               w_ptr_next;

  // --------------------------------------------------------------------------
  // Target selection
  // --------------------------------------------------------------------------
`ifdef LINK_SKIP_BUSY_EN
  assign w_mask  = bus.link_en & w_has_credit;
  assign w_ready = w_sel.found;
`else
  logic w_tgt_credit;

  always_comb begin
    w_tgt_credit = 1'b0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (w_sel.idx == LINK_IDX_W'(i)) begin
        w_tgt_credit = w_has_credit[i];
      end
    end
  end

  assign w_mask  = bus.link_en;
  assign w_ready = w_sel.found & w_tgt_credit;
`endif

  assign w_sel    = next_enabled(MAX_LINKS'(w_mask), LINK_IDX_W'(r_ptr), NUM_LINKS);
  assign w_accept = bus.in_valid & w_ready;

  // One-hot send vector; at most one link fires per cycle.
  always_comb begin
    w_send = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      w_send[i] = w_accept && (w_sel.idx == LINK_IDX_W'(i));
    end
  end

  assign w_ptr_next = (w_sel.idx == LINK_IDX_W'(NUM_LINKS - 1)) ? '0
                                                                 : PW'(w_sel.idx + LINK_IDX_W'(1));

  // --------------------------------------------------------------------------
  // Output registers, stripe pointer and sequence counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_seq        <= '0;
      r_link_valid <= '0;
      r_link_flit  <= '0;
      r_link_seq   <= '0;
    end else begin
      // Unsent slices keep their last flit/seq; valid is a one-cycle pulse.
      r_link_valid <= w_send;
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (w_send[i]) begin
          r_link_flit[i*FLIT_W +: FLIT_W] <= bus.in_flit;
          r_link_seq[i*SEQ_W +: SEQ_W]    <= r_seq;
        end
      end
      if (w_accept) begin
        r_seq <= r_seq + SEQ_W'(1);
        r_ptr <= w_ptr_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-link credit counters
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_credit
    link_credit_ctr #(
      .CREDITS (CREDITS),
      .CW      (CW)
    ) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .send       (w_send[g]),
      .ret        (bus.link_credit[g]),
      .cnt        (w_credit_cnt[g*CW +: CW]),
      .has_credit (w_has_credit[g]),
      .ovf        (w_ovf[g])
    );
  end

  assign bus.in_ready       = w_ready;
  assign bus.link_valid     = r_link_valid;
  assign bus.link_flit      = r_link_flit;
  assign bus.link_seq       = r_link_seq;
  assign bus.credit_cnt     = w_credit_cnt;
  assign bus.err_credit_ovf = |w_ovf;

endmodule

`default_nettype wire
